// File: rtl/toast_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : toast_mem_responder
// Brief    : Memory-side responder for toast_top. One word-addressed RAM
//            serves the IMEM fetch port and the DMEM load/store port with
//            registered reads and byte-enable writes. A byte-stream loader
//            fills the RAM while the core is held in reset, and a tohost
//            mailbox reports riscv-tests pass/fail.
// Revision : 1.0 - initial release
// ============================================================================
module toast_mem_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          ADDR_W      = 12,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_3FFC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // instruction fetch port
    input  logic [31:0] IMEM_addr_i,
    output logic [31:0] IMEM_data_o,
    // data load/store port
    input  logic [31:0] DMEM_addr_i,
    input  logic [3:0]  DMEM_wr_byte_en_i,
    input  logic [31:0] DMEM_wr_data_i,
    output logic [31:0] DMEM_rd_data_o,
    input  logic        DMEM_rst_i,
    // byte-stream loader
    input  logic        load_valid_i,
    input  logic [7:0]  load_byte_i,
    input  logic        load_last_i,
    output logic        load_ready_o,
    // core control and status
    output logic        core_resetn_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [30:0] fail_id_o,
    output logic        load_ovf_o
);

    // Word count at which the RAM is full and further loader bytes are dropped.
    localparam logic [ADDR_W:0] c_DEPTH_CNT   = (ADDR_W + 1)'(DEPTH_WORDS);
    localparam logic [29:0]     c_TOHOST_WORD = TOHOST_ADDR[31:2];

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [31:0]       r_mem [DEPTH_WORDS];

    logic [1:0]        r_byte_cnt;
    logic [ADDR_W:0]   r_word_cnt;
    logic [31:0]       r_pack;
    logic              r_ovf;

    logic [31:0]       r_imem_data;
    logic [31:0]       r_dmem_data;
    logic              r_done;
    logic              r_pass;
    logic [30:0]       r_fail_id;
    logic              r_core_resetn;

    logic              w_load_accept;
    logic              w_load_full;
    logic              w_load_wr;
    logic              w_core_wr;
    logic              w_tohost_hit;
    logic [31:0]       w_pack_word;
    logic [ADDR_W-1:0] w_imem_idx;
    logic [ADDR_W-1:0] w_dmem_idx;
    logic [ADDR_W-1:0] w_load_idx;
    logic              w_unused;

    // Byte-lane offset bits and aliased upper fetch bits play no part in indexing.
    assign w_unused = ^{IMEM_addr_i[31:ADDR_W+2], IMEM_addr_i[1:0], DMEM_addr_i[1:0]};

    assign w_imem_idx  = IMEM_addr_i[ADDR_W+1:2];
    assign w_dmem_idx  = DMEM_addr_i[ADDR_W+1:2];
    assign w_load_idx  = r_word_cnt[ADDR_W-1:0];
    assign w_load_full = (r_word_cnt == c_DEPTH_CNT);
    // Incoming byte merged into its lane; lanes not yet received stay zero.
    assign w_pack_word = r_pack | (32'(load_byte_i) << {r_byte_cnt, 3'b000});

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-state enables.
    always_comb begin
        w_state_next  = r_state;
        w_load_accept = 1'b0;
        w_core_wr     = 1'b0;
        w_tohost_hit  = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_load_accept = load_valid_i;
                if (load_valid_i && load_last_i) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_core_wr    = |DMEM_wr_byte_en_i;
                w_tohost_hit = (DMEM_addr_i[31:2] == c_TOHOST_WORD) &&
                               (DMEM_wr_byte_en_i == 4'hF) &&
                               (DMEM_wr_data_i != 32'd0);
                if (w_tohost_hit) begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    // A word is committed on its 4th byte or on the final loader byte.
    assign w_load_wr = w_load_accept && !w_load_full &&
                       ((r_byte_cnt == 2'd3) || load_last_i);

    assign load_ready_o = (r_state == ST_LOAD);

    // Loader packing, word counter and overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_byte_cnt <= 2'd0;
            r_word_cnt <= '0;
            r_pack     <= 32'd0;
            r_ovf      <= 1'b0;
        end else if (w_load_accept) begin
            if (w_load_full) begin
                r_ovf <= 1'b1;
            end else if (w_load_wr) begin
                r_pack     <= 32'd0;
                r_byte_cnt <= 2'd0;
                r_word_cnt <= r_word_cnt + 1'b1;
            end else begin
                r_pack     <= w_pack_word;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
        end
    end

    // RAM write port: loader words in LOAD, byte-enabled core stores in RUN.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (w_load_wr) begin
                r_mem[w_load_idx] <= w_pack_word;
            end else if (w_core_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (DMEM_wr_byte_en_i[b]) begin
                        r_mem[w_dmem_idx][8*b +: 8] <= DMEM_wr_data_i[8*b +: 8];
                    end
                end
            end
        end
    end

    // Registered read ports; non-blocking update gives read-first on collisions.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_imem_data <= 32'd0;
            r_dmem_data <= 32'd0;
        end else begin
            r_imem_data <= r_mem[w_imem_idx];
            r_dmem_data <= DMEM_rst_i ? 32'd0 : r_mem[w_dmem_idx];
        end
    end

    // Mailbox result capture, frozen once the first qualifying store lands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail_id <= 31'd0;
        end else if (w_tohost_hit) begin
            r_done    <= 1'b1;
            r_pass    <= (DMEM_wr_data_i == 32'd1);
            r_fail_id <= DMEM_wr_data_i[31:1];
        end
    end

    // Core runs only while the next state is RUN; released as loading ends.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_core_resetn <= 1'b0;
        end else begin
            r_core_resetn <= (w_state_next == ST_RUN);
        end
    end

    assign IMEM_data_o    = r_imem_data;
    assign DMEM_rd_data_o = r_dmem_data;
    assign done_o         = r_done;
    assign pass_o         = r_pass;
    assign fail_id_o      = r_fail_id;
    assign load_ovf_o     = r_ovf;
    assign core_resetn_o  = r_core_resetn;

endmodule
`default_nettype wire
